// File: rtl/inst_share_sched.sv
// inst_share_sched: shares one fixed-latency `inst` unit (lower_ina/lower_inb -> lower_out)
// between NREQ requesters using round-robin arbitration, one transaction at a time.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_vec[NREQ]      per-requester request level (held until its grant pulse)
//   ina_vec/inb_vec    per-requester operands, captured at the selection edge
//   gnt_vec[NREQ]      one-hot grant pulse (ISSUE cycle)
//   rsp_valid[NREQ]    one-hot response pulse (RESP cycle)
//   rsp_data           result bit, qualified by rsp_valid
//   lower_ina/inb      drive inst.lower_ina / inst.lower_inb
//   lower_out          from inst.lower_out, sampled LAT cycles after issue
//   busy               high whenever the FSM is not in IDLE
//
// Optional build macro INST_SHARE_SCHED_STATS_EN adds:
//   grant_cnt[16]      saturating count of ISSUE cycles
//   starve             sticky flag: a requester waited 64 consecutive cycles ungranted
//
// All outputs are registered: each is loaded from its next-state value, so it
// changes on the same edge as the FSM state it belongs to.

module inst_share_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_vec,
  input  logic [NREQ-1:0] ina_vec,
  input  logic [NREQ-1:0] inb_vec,
  output logic [NREQ-1:0] gnt_vec,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_data,
  output logic            lower_ina,
  output logic            lower_inb,
  input  logic            lower_out,
  output logic            busy
`ifdef INST_SHARE_SCHED_STATS_EN
  ,
  output logic [15:0]     grant_cnt,
  output logic            starve
`endif
);

  // Search index needs one extra bit so rr_ptr + offset can exceed NREQ before wrapping.
  localparam int unsigned PW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   wcnt, wcnt_nxt;
  logic [IW-1:0]   sel_idx, sel_nxt;
  logic            lat_ina, lat_ina_nxt;
  logic            lat_inb, lat_inb_nxt;

  logic [NREQ-1:0] gnt_nxt;
  logic [NREQ-1:0] rsp_valid_nxt;
  logic            rsp_data_nxt;
  logic            lower_ina_nxt;
  logic            lower_inb_nxt;
  logic            busy_nxt;

  logic            found;
  logic [IW-1:0]   pick;
  logic            pick_ina;
  logic            pick_inb;

  // One-hot vector with bit i set; shifting avoids indexing with an oversized index.
  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin search: first set request bit at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [PW-1:0]   idx;
    logic [NREQ-1:0] req_sh;
    found  = 1'b0;
    pick   = '0;
    idx    = '0;
    req_sh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + PW'(i);
      if (idx >= PW'(NREQ)) begin
        idx = idx - PW'(NREQ);
      end
      req_sh = req_vec >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // Operands of the winning requester, captured only at the selection edge.
  always_comb begin
    logic [NREQ-1:0] ina_sh;
    logic [NREQ-1:0] inb_sh;
    ina_sh   = ina_vec >> pick;
    inb_sh   = inb_vec >> pick;
    pick_ina = ina_sh[0];
    pick_inb = inb_sh[0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    wcnt_nxt      = wcnt;
    sel_nxt       = sel_idx;
    lat_ina_nxt   = lat_ina;
    lat_inb_nxt   = lat_inb;
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    rsp_data_nxt  = 1'b0;
    lower_ina_nxt = 1'b0;
    lower_inb_nxt = 1'b0;
    busy_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = ISSUE;
          sel_nxt       = pick;
          lat_ina_nxt   = pick_ina;
          lat_inb_nxt   = pick_inb;
          rr_nxt        = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);
          gnt_nxt       = onehot(pick);
          lower_ina_nxt = pick_ina;
          lower_inb_nxt = pick_inb;
        end
      end

      ISSUE: begin
        state_nxt     = WAIT;
        wcnt_nxt      = IW'(LAT);
        lower_ina_nxt = lat_ina;
        lower_inb_nxt = lat_inb;
      end

      WAIT: begin
        wcnt_nxt = wcnt - IW'(1);
        if (wcnt == IW'(1)) begin
          // Last wait cycle: lower_out is valid now; RESP drives the unit inputs low.
          state_nxt     = RESP;
          rsp_valid_nxt = onehot(sel_idx);
          rsp_data_nxt  = lower_out;
        end else begin
          lower_ina_nxt = lat_ina;
          lower_inb_nxt = lat_inb;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wcnt      <= '0;
      sel_idx   <= '0;
      lat_ina   <= 1'b0;
      lat_inb   <= 1'b0;
      gnt_vec   <= '0;
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      lower_ina <= 1'b0;
      lower_inb <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      wcnt      <= wcnt_nxt;
      sel_idx   <= sel_nxt;
      lat_ina   <= lat_ina_nxt;
      lat_inb   <= lat_inb_nxt;
      gnt_vec   <= gnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      lower_ina <= lower_ina_nxt;
      lower_inb <= lower_inb_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef INST_SHARE_SCHED_STATS_EN
  // Per-requester count of consecutive ungranted request cycles, saturating at 64.
  logic [6:0] starve_cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      starve    <= 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
        starve_cnt[i] <= '0;
      end
    end else begin
      if (state == ISSUE && grant_cnt != 16'hFFFF) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_vec[i] && !gnt_vec[i]) begin
          if (starve_cnt[i] != 7'd64) begin
            starve_cnt[i] <= starve_cnt[i] + 7'd1;
          end
          // This edge completes the 64th consecutive waiting cycle.
          if (starve_cnt[i] == 7'd63) begin
            starve <= 1'b1;
          end
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_share_sched.sv
// Directed self-checking bench for inst_share_sched (NREQ=4, LAT=2, default build).
// A behavioural model of the shared unit computes lower_ina ^ lower_inb with a
// two-cycle delay. Outputs are sampled 1 time unit after each rising edge.

module tb_inst_share_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vec;
  logic [3:0] ina_vec;
  logic [3:0] inb_vec;
  logic [3:0] gnt_vec;
  logic [3:0] rsp_valid;
  logic       rsp_data;
  logic       lower_ina;
  logic       lower_inb;
  logic       lower_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  inst_share_sched #(.NREQ(4), .LAT(2), .IW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vec   (req_vec),
    .ina_vec   (ina_vec),
    .inb_vec   (inb_vec),
    .gnt_vec   (gnt_vec),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .lower_ina (lower_ina),
    .lower_inb (lower_inb),
    .lower_out (lower_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared unit model: xor of its inputs, two-cycle pipeline.
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= lower_ina ^ lower_inb;
    d2 <= d1;
  end
  assign lower_out = d2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {gnt_vec, rsp_valid, rsp_data, lower_ina, lower_inb, busy}.
  task automatic chk(input string tag, input logic [3:0] g, input logic [3:0] v,
                     input logic d, input logic a, input logic b, input logic bs);
    logic [11:0] obs;
    logic [11:0] exp;
    obs = {gnt_vec, rsp_valid, rsp_data, lower_ina, lower_inb, busy};
    exp = {g, v, d, a, b, bs};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b_%b_%b%b%b%b expected %b_%b_%b%b%b%b", tag,
             obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
             exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One full transaction from an IDLE cycle: selection, ISSUE, 2x WAIT, RESP, IDLE.
  // After the grant, req/ina/inb switch to the *_after values.
  task automatic txn(input string tag,
                     input logic [3:0] req_set, input logic [3:0] ina_set, input logic [3:0] inb_set,
                     input logic [3:0] req_after, input logic [3:0] ina_after, input logic [3:0] inb_after,
                     input logic [3:0] g, input logic a, input logic b, input logic d);
    req_vec = req_set;
    ina_vec = ina_set;
    inb_vec = inb_set;
    tick();
    chk({tag, ".issue"}, g, 4'b0000, 1'b0, a, b, 1'b1);
    req_vec = req_after;
    ina_vec = ina_after;
    inb_vec = inb_after;
    tick();
    chk({tag, ".wait1"}, 4'b0000, 4'b0000, 1'b0, a, b, 1'b1);
    tick();
    chk({tag, ".wait2"}, 4'b0000, 4'b0000, 1'b0, a, b, 1'b1);
    tick();
    chk({tag, ".resp"}, 4'b0000, g, d, 1'b0, 1'b0, 1'b1);
    tick();
    chk({tag, ".idle"}, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    req_vec = 4'b0000;
    ina_vec = 4'b0000;
    inb_vec = 4'b0000;
    tick();
    tick();
    chk("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_noreq", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_noreq2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single request from requester 1, ina=1 inb=0 -> result 1.
    txn("single", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
        4'b0010, 1'b1, 1'b0, 1'b1);

    // Reset pointer back to 0 before fairness run.
    rst = 1'b1;
    tick();
    chk("reset2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // All four requesting: grants 0,1,2,3,0 every 5 cycles. xor pattern 1100.
    txn("rr0", 4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0);
    txn("rr1", 4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, 4'b0010, 1'b1, 1'b1, 1'b0);
    txn("rr2", 4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, 4'b0100, 1'b0, 1'b1, 1'b1);
    txn("rr3", 4'b1111, 4'b1010, 4'b0110, 4'b1111, 4'b1010, 4'b0110, 4'b1000, 1'b1, 1'b0, 1'b1);
    txn("rr4", 4'b1111, 4'b1010, 4'b0110, 4'b0000, 4'b1010, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b0);
    // rr_ptr is now 1; grant requester 2 to move it to 3.
    txn("ptr3", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);

    // Wrap and skip from rr_ptr=3 with 0101: grant 0 then 2, pointer back at 3.
    txn("wrap0", 4'b0101, 4'b0001, 4'b0100, 4'b0101, 4'b0001, 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b1);
    txn("wrap2", 4'b0101, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1);
    txn("after3", 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);

    // Early drop: requester 2 drops req and its ina toggles after grant; latched value wins.
    txn("drop", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1);

    // rr_ptr=3; 0110 grants requester 1 (ptr would become 2), then reset mid-WAIT.
    req_vec = 4'b0110;
    ina_vec = 4'b0010;
    inb_vec = 4'b0100;
    tick();
    chk("rst.issue", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rst.wait1", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst.async", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst.held", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    // Pointer reset to 0: lowest requester (1) is granted again, not requester 2.
    txn("postrst", 4'b0110, 4'b0010, 4'b0100, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 1'b1, 1'b0, 1'b1);
    tick();
    chk("final_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
